nibble_serial_add_ctrl: RTL and testbench

Sequencer that performs WIDTH-bit additions by time-multiplexing a single 4-bit ripple adder slice, one nibble per clock, LSB nibble first. The carry is chained through a register between nibbles. Operands and results use valid/ready handshakes. It lets wide-word arithmetic reuse the team's 4-bit adder datapath instead of instantiating a WIDTH-bit adder.

---
 rtl/add_pkg.sv | 17 +
 rtl/add4_slice.sv | 23 ++
 rtl/nibble_serial_add_ctrl.sv | 112 +++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared types and helpers for the nibble-serial adder controller.
package add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int NIB_W = 4;

    // Index width for a counter over n steps; never narrower than one bit.
    function automatic int clog2_safe(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add4_slice.sv
// Combinational 4-bit ripple-carry adder slice, reused once per nibble step.
module add4_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] carry;

    assign carry[0] = ci;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign s[gi]       = x[gi] ^ y[gi] ^ carry[gi];
            assign carry[gi+1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign co = carry[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder built by stepping a single 4-bit slice over the operands,
// LSB nibble first, with the carry chained through a register.
module nibble_serial_add_ctrl
    import add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = clog2_safe(NIB);

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             c_out_reg;

    logic [NIB_W-1:0] a_nib [NIB];
    logic [NIB_W-1:0] b_nib [NIB];

    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[gi*NIB_W +: NIB_W];
            assign b_nib[gi] = b_reg[gi*NIB_W +: NIB_W];
        end
    endgenerate

    logic [NIB_W-1:0] slice_s;
    logic             slice_co;
    logic             last_step;

    add4_slice u_slice (
        .x  (a_nib[idx_reg]),
        .y  (b_nib[idx_reg]),
        .ci (carry_reg),
        .s  (slice_s),
        .co (slice_co)
    );

    assign last_step = (idx_reg == IDX_W'(NIB - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= c_in;
                        sum_reg   <= '0;
                        idx_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[idx_reg*NIB_W +: NIB_W] <= slice_s;
                    carry_reg <= slice_co;
                    if (last_step) begin
                        c_out_reg <= slice_co;
                        idx_reg   <= '0;
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                DONE: begin
                    // Result stays put until the consumer takes it; new operands wait for IDLE.
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign sum       = sum_reg;
    assign c_out     = c_out_reg;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed-vector and random self-checking bench for nibble_serial_add_ctrl (WIDTH=16).
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    int n_pass  = 0;
    int n_total = 0;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vc;
        logic [15:0] exp_sum;
        logic        exp_cout;
        int          gap;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Wait on the falling edge until out_valid, counting rising edges; bounded.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                         input logic [15:0] exp_sum, input logic exp_cout,
                         input int gap, input string tag);
        int   cyc;
        logic stable;
        @(negedge clk);
        a = va; b = vb; c_in = vc; in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_in_ready_before"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        c_in = 1'($urandom);
        check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_accept_clears_sum"}, 32'(sum), 32'd0);
        wait_out(cyc);
        check({tag, "_latency"}, 32'(cyc), 32'(NIB));
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_c_out"}, 32'(c_out), 32'(exp_cout));
        stable = 1'b1;
        repeat (gap) begin
            @(negedge clk);
            if (!out_valid || sum !== exp_sum || c_out !== exp_cout || in_ready) stable = 1'b0;
        end
        check({tag, "_backpressure_hold"}, 32'(stable), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_release_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_sum_retained"}, 32'(sum), 32'(exp_sum));
        $display("op %s: a=%04h b=%04h c_in=%0d -> sum=%04h c_out=%0d (exp %04h/%0d) lat=%0d",
                 tag, va, vb, vc, sum, c_out, exp_sum, exp_cout, cyc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic        seen;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] rexp;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 0};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 5};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 2};
        vecs[6] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 0};
        vecs[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 3};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_c_out", 32'(c_out), 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].exp_sum, vecs[i].exp_cout,
                  vecs[i].gap, $sformatf("vec%0d", i));
        end

        // Operands offered during RUN/DONE must wait for IDLE.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; c_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 16'hAAAA;
        check("busy_in_ready", 32'(in_ready), 32'd0);
        wait_out(cyc);
        check("busy_latency", 32'(cyc), 32'(NIB));
        check("busy_sum", 32'(sum), 32'h0100);
        check("busy_c_out", 32'(c_out), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("busy_done_out_valid", 32'(out_valid), 32'd0);
        check("busy_done_in_ready", 32'(in_ready), 32'd1);
        check("busy_done_sum_kept", 32'(sum), 32'h0100);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_second_accepted", 32'(in_ready), 32'd0);
        check("busy_second_sum_clear", 32'(sum), 32'd0);
        wait_out(cyc);
        check("busy_second_sum", 32'(sum), 32'hAAAB);
        check("busy_second_c_out", 32'(c_out), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        $display("op busy: first=0100 second=AAAB sequence done");

        // Abort mid-operation; c_out is set beforehand so the reset clear is visible.
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0, "pre_reset");
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_c_out", 32'(c_out), 32'd0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_out_valid", 32'(seen), 32'd0);
        $display("op abort: reset at second RUN edge");

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rexp = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(ra, rb, rc, rexp[15:0], rexp[16], int'($urandom_range(0, 3)),
                  $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
